l2_port_arbiter: RTL and testbench

//  Shares one single-ported L2/memory port between NUM_REQ cache miss engines (I$ and D$ by default).

---
 rtl/l2_port_arbiter_pkg.sv | 22 ++
 rtl/l2_port_arbiter_rr_pick.sv | 27 ++
 rtl/l2_port_arbiter.sv | 139 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L2 port arbiter: FSM state encoding, cache word-block type
// and the round-robin pointer wrap helper.
package l2_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int WORD_W       = 32;
  localparam int CACHE_BLOCKS = 4;

  // One cache block as seen on the cache_module mem_* ports.
  typedef logic [CACHE_BLOCKS-1:0][WORD_W-1:0] word_block_t;

  // Next round-robin position after idx, wrapping modulo n (n need not be a power of 2).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// rr_ptr (searching circularly) and whether any requester is active.
module l2_port_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  int idx;

  // Scan offsets from farthest to nearest so the closest requester to rr_ptr wins.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one single-ported L2 port between NUM_REQ cache miss engines.
// Round-robin grant in IDLE; after a write-back the grant is held for up to
// HOLD_CYCLES so the evicting cache can issue its refill before anyone else.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BLOCKS      = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    up_req,
  input  logic [NUM_REQ-1:0]                    up_we,
  input  logic [NUM_REQ-1:0][31:0]              up_addr,
  input  logic [NUM_REQ-1:0][BLOCKS-1:0][31:0]  up_wblock,
  output logic [NUM_REQ-1:0]                    up_miss,
  output logic [BLOCKS-1:0][31:0]               up_rblock,
  output logic                                  dn_req,
  output logic                                  dn_we,
  output logic [31:0]                           dn_addr,
  output logic [BLOCKS-1:0][31:0]               dn_wblock,
  input  logic [BLOCKS-1:0][31:0]               dn_rblock,
  input  logic                                  dn_miss,
  output logic [IW-1:0]                         grant_id,
  output logic                                  busy
);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

  logic [IW-1:0] winner;
  logic          any_valid;
  logic [IW-1:0] sel;
  logic          fwd;
  logic          done;

  l2_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req       (up_req),
    .rr_ptr    (rr_ptr_reg),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // In IDLE the fresh winner is forwarded with zero latency; otherwise the owner keeps the port.
  assign sel  = (state_reg == IDLE) ? winner : grant_reg;
  assign fwd  = reset & ((state_reg == IDLE) ? any_valid : up_req[grant_reg]);
  assign done = fwd & ~dn_miss;

  assign dn_req    = fwd;
  assign dn_we     = fwd & up_we[sel];
  assign dn_addr   = fwd ? up_addr[sel] : 32'd0;
  assign dn_wblock = fwd ? up_wblock[sel] : '0;
  assign up_rblock = dn_rblock;
  assign grant_id  = reset ? sel : '0;
  assign busy      = (state_reg != IDLE);

  // Only the owner sees its request finish; everyone else keeps seeing miss while requesting.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_miss
      assign up_miss[gi] = reset & up_req[gi] & ~(done & (sel == IW'(gi)));
    end
  endgenerate

  // State, grant owner, round-robin pointer and hold counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Next-state logic: a completed write enters HOLD, a completed read releases the port.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          grant_next = winner;
          if (done) begin
            if (up_we[winner]) begin
              state_next    = HOLD;
              hold_cnt_next = '0;
            end else begin
              state_next  = IDLE;
              rr_ptr_next = IW'(rr_wrap(int'(winner), NUM_REQ));
            end
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE, HOLD: begin
        if (up_req[grant_reg]) begin
          if (done) begin
            if (up_we[grant_reg]) begin
              state_next    = HOLD;
              hold_cnt_next = '0;
            end else begin
              state_next  = IDLE;
              rr_ptr_next = IW'(rr_wrap(int'(grant_reg), NUM_REQ));
            end
          end else begin
            state_next = ISSUE;
          end
        end else if (state_reg == ISSUE) begin
          // Owner abandoned its request mid-transaction.
          state_next  = IDLE;
          rr_ptr_next = IW'(rr_wrap(int'(grant_reg), NUM_REQ));
        end else if (hold_cnt_reg == HW'(HOLD_CYCLES - 1)) begin
          // No refill arrived in time; let the others in.
          state_next  = IDLE;
          rr_ptr_next = IW'(rr_wrap(int'(grant_reg), NUM_REQ));
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: a latency-programmable L2 model,
// per-requester drivers and an in-order completion scoreboard.
module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int BLOCKS      = 4;
  localparam int HOLD_CYCLES = 2;

  logic                                 clock = 1'b0;
  logic                                 reset = 1'b0;
  logic [NUM_REQ-1:0]                   up_req;
  logic [NUM_REQ-1:0]                   up_we;
  logic [NUM_REQ-1:0][31:0]             up_addr;
  logic [NUM_REQ-1:0][BLOCKS-1:0][31:0] up_wblock;
  logic [NUM_REQ-1:0]                   up_miss;
  logic [BLOCKS-1:0][31:0]              up_rblock;
  logic                                 dn_req;
  logic                                 dn_we;
  logic [31:0]                          dn_addr;
  logic [BLOCKS-1:0][31:0]              dn_wblock;
  logic [BLOCKS-1:0][31:0]              dn_rblock;
  logic                                 dn_miss;
  logic [0:0]                           grant_id;
  logic                                 busy;

  logic        req_d  [NUM_REQ];
  logic        we_d   [NUM_REQ];
  logic [31:0] addr_d [NUM_REQ];
  word_block_t wb_d   [NUM_REQ];

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    word_block_t data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   l2_lat = 3;
  int   l2_cnt = 0;

  l2_port_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .BLOCKS      (BLOCKS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .up_req    (up_req),
    .up_we     (up_we),
    .up_addr   (up_addr),
    .up_wblock (up_wblock),
    .up_miss   (up_miss),
    .up_rblock (up_rblock),
    .dn_req    (dn_req),
    .dn_we     (dn_we),
    .dn_addr   (dn_addr),
    .dn_wblock (dn_wblock),
    .dn_rblock (dn_rblock),
    .dn_miss   (dn_miss),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // L2 contents are a fixed function of the address.
  function automatic word_block_t l2_data(input logic [31:0] a);
    word_block_t d;
    for (int k = 0; k < BLOCKS; k++) d[k] = (a << 4) ^ (32'hA5A5_0000 + 32'(k));
    return d;
  endfunction

  // Drive the DUT request ports from the per-requester driver variables.
  always_comb begin
    up_req    = '0;
    up_we     = '0;
    up_addr   = '0;
    up_wblock = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      up_req[i]    = req_d[i];
      up_we[i]     = we_d[i];
      up_addr[i]   = addr_d[i];
      up_wblock[i] = wb_d[i];
    end
  end

  // L2 model: completes when a request has been held for l2_lat cycles.
  always_comb begin
    dn_miss   = dn_req && (l2_cnt != l2_lat);
    dn_rblock = l2_data(dn_addr);
  end

  // L2 latency counter.
  always @(posedge clock) begin
    if (!dn_req || !dn_miss) l2_cnt <= 0;
    else                     l2_cnt <= l2_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int id, input logic we, input logic [31:0] addr,
                                   input word_block_t wb);
    exp_t e;
    e.id   = id;
    e.we   = we;
    e.addr = addr;
    e.data = we ? wb : l2_data(addr);
    exp_q.push_back(e);
  endfunction

  // Completion monitor: every finished transaction must be the next expected one.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (up_req[i] && !up_miss[i]) begin
          check_eq("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            $display("txn done req=%0d we=%0d addr=%08h t=%0t", i, dn_we, dn_addr, $time);
            check_eq("done_id", 128'(i), 128'(mon_e.id));
            check_eq("dn_addr", dn_addr, mon_e.addr);
            check_eq("dn_we", dn_we, mon_e.we);
            check_eq("grant_id", grant_id, 128'(i));
            if (mon_e.we) check_eq("dn_wblock", dn_wblock, mon_e.data);
            else          check_eq("up_rblock", up_rblock, mon_e.data);
            for (int j = 0; j < NUM_REQ; j++)
              if (j != i && up_req[j]) check_eq("loser_miss", up_miss[j], 1'b1);
          end
        end
      end
    end
  end

  // Issue one request from requester id and wait (bounded) for its completion.
  task automatic req_txn(input int id, input logic we, input logic [31:0] addr,
                         input word_block_t wb, output int n);
    bit fin;
    @(posedge clock);
    #1;
    req_d[id]  = 1'b1;
    we_d[id]   = we;
    addr_d[id] = addr;
    wb_d[id]   = wb;
    n   = 0;
    fin = 0;
    while (!fin && n < 60) begin
      @(negedge clock);
      n++;
      if (reset && !up_miss[id]) fin = 1;
    end
    check_eq("txn_done", 128'(fin), 128'd1);
    @(posedge clock);
    #1;
    req_d[id]  = 1'b0;
    we_d[id]   = 1'b0;
    addr_d[id] = '0;
    wb_d[id]   = '0;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2, n3;
    word_block_t wb_a, wb_b;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_d[i] = 0; we_d[i] = 0; addr_d[i] = '0; wb_d[i] = '0;
    end
    wb_a = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    wb_b = {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};

    // Reset state, with a request asserted that must not leak through.
    req_d[1] = 1; we_d[1] = 1; addr_d[1] = 32'h55;
    repeat (3) @(negedge clock);
    check_eq("rst_dn_req", dn_req, 1'b0);
    check_eq("rst_dn_we", dn_we, 1'b0);
    check_eq("rst_dn_addr", dn_addr, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_up_miss", up_miss, 2'b00);
    check_eq("rst_grant", grant_id, 1'b0);
    check_eq("rst_rblock", up_rblock, l2_data(32'h0));
    req_d[1] = 0; we_d[1] = 0; addr_d[1] = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single D$ read.
    l2_lat = 3;
    push_exp(1, 1'b0, 32'h100, '0);
    req_txn(1, 1'b0, 32'h100, '0, n0);
    check_eq("t1_latency", n0, 4);

    // Simultaneous I$/D$ reads, rr_ptr back at 0.
    push_exp(0, 1'b0, 32'h40, '0);
    push_exp(1, 1'b0, 32'h80, '0);
    fork
      req_txn(0, 1'b0, 32'h40, '0, n0);
      req_txn(1, 1'b0, 32'h80, '0, n1);
    join
    check_eq("t2_i_cycles", n0, 4);
    check_eq("t2_d_cycles", n1, 8);

    // D$ write-back then refill after a 1-cycle gap, I$ waiting.
    push_exp(1, 1'b1, 32'h200, wb_a);
    push_exp(1, 1'b0, 32'h300, '0);
    push_exp(0, 1'b0, 32'h44, '0);
    fork
      begin
        req_txn(1, 1'b1, 32'h200, wb_a, n0);
        @(negedge clock);
        check_eq("t3_hold_busy", busy, 1'b1);
        check_eq("t3_hold_grant", grant_id, 1'b1);
        check_eq("t3_hold_dn_req", dn_req, 1'b0);
        check_eq("t3_hold_imiss", up_miss[0], 1'b1);
        req_txn(1, 1'b0, 32'h300, '0, n1);
      end
      begin
        @(posedge clock);
        req_txn(0, 1'b0, 32'h44, '0, n2);
      end
    join
    check_eq("t3_wb_cycles", n0, 4);
    check_eq("t3_refill_cycles", n1, 4);
    check_eq("t3_i_cycles", n2, 12);

    // D$ write-back without refill: HOLD times out, I$ gets the port.
    push_exp(1, 1'b1, 32'h210, wb_b);
    push_exp(0, 1'b0, 32'h48, '0);
    fork
      begin
        req_txn(1, 1'b1, 32'h210, wb_b, n0);
        @(negedge clock);
        check_eq("t4_hold0_req", dn_req, 1'b0);
        @(negedge clock);
        check_eq("t4_hold1_req", dn_req, 1'b0);
        check_eq("t4_hold1_busy", busy, 1'b1);
        @(negedge clock);
        check_eq("t4_exit_req", dn_req, 1'b1);
        check_eq("t4_exit_addr", dn_addr, 32'h48);
        check_eq("t4_exit_busy", busy, 1'b0);
      end
      begin
        @(posedge clock);
        req_txn(0, 1'b0, 32'h48, '0, n1);
      end
    join
    check_eq("t4_i_cycles", n1, 9);

    // Zero-latency L2: strict 0,1,0,1 alternation from a fresh rr_ptr.
    apply_reset();
    l2_lat = 0;
    push_exp(0, 1'b0, 32'h500, '0);
    push_exp(1, 1'b0, 32'h600, '0);
    push_exp(0, 1'b0, 32'h504, '0);
    push_exp(1, 1'b0, 32'h604, '0);
    fork
      begin
        req_txn(0, 1'b0, 32'h500, '0, n0);
        req_txn(0, 1'b0, 32'h504, '0, n2);
      end
      begin
        req_txn(1, 1'b0, 32'h600, '0, n1);
        req_txn(1, 1'b0, 32'h604, '0, n3);
      end
    join
    check_eq("t5_first0", n0, 1);
    check_eq("t5_first1", n1, 2);
    check_eq("t5_second0", n2, 1);
    check_eq("t5_second1", n3, 1);

    // Reset pulse during an ISSUE wait; the held request is re-forwarded afterwards.
    l2_lat = 3;
    push_exp(0, 1'b0, 32'h60, '0);
    fork
      req_txn(0, 1'b0, 32'h60, '0, n0);
      begin
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_dn_req", dn_req, 1'b0);
        check_eq("t6_rst_busy", busy, 1'b0);
        check_eq("t6_rst_miss", up_miss, 2'b00);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_eq("t6_refwd_req", dn_req, 1'b1);
        check_eq("t6_refwd_addr", dn_addr, 32'h60);
      end
    join
    check_eq("t6_cycles", n0, 6);

    repeat (3) @(posedge clock);
    check_eq("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
